// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// Receive-side decoder for one TMDS channel. Finds 10-bit word alignment by
// bit-slipping until a run of control tokens is seen, then decodes video
// symbols (10b->8b) and control tokens ({c1,c0}).
//
// Ports:
//   clk_pixel   in   symbol-rate clock, all logic on the rising edge
//   reset       in   synchronous, active-high
//   symbol_in   in   [9:0] raw deserialized symbol, bit 0 first on the wire
//   data_out    out  [7:0] decoded video byte, 0 whenever de=0
//   ctrl_out    out  [1:0] {c1,c0} of the most recent control token
//   de          out  video byte valid (video symbol while locked)
//   locked      out  word alignment locked
//   slip_offset out  [3:0] current bit rotation, 0..9
//
// state     | meaning
// SEARCH    | hunting for LOCK_TOKENS consecutive tokens at slip_offset
// SLIP_WAIT | flushing the alignment pipeline after a bit slip
// LOCKED    | alignment found, video decodes with de=1

module tmds_channel_decoder #(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int SLIP_WAIT      = 3
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] symbol_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_offset
);

    localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
    localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [TOK_W-1:0]  TOK_MAX   = TOK_W'(LOCK_TOKENS);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TOK_W-1:0]    tok_cnt_q, tok_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]          slip_q, slip_d;

    logic [9:0]          prev_q;
    logic [9:0]          aligned_q;
    logic [7:0]          data_q;
    logic [1:0]          ctrl_q;
    logic                de_q;

    logic [19:0]         window;
    logic [9:0]          aligned;
    logic                is_tok;
    logic [1:0]          tok_ctrl;
    logic [7:0]          vid_v;
    logic [7:0]          vid_byte;
    logic [TOK_W-1:0]    tok_run;
    logic                tok_qual;
    logic                tmo_expire;

    // Two consecutive symbols give every possible 10-bit framing; bit 0 of
    // the older symbol is the earliest bit on the wire.
    assign window  = {symbol_in, prev_q};
    assign aligned = 10'(window >> slip_q);

    always_comb begin
        is_tok   = 1'b1;
        tok_ctrl = 2'b00;
        case (aligned_q)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: is_tok   = 1'b0;
        endcase
    end

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8).
    always_comb begin
        vid_v    = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        vid_byte = {aligned_q[8] ? (vid_v[7:1] ^ vid_v[6:0])
                                 : ~(vid_v[7:1] ^ vid_v[6:0]),
                    vid_v[0]};
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            prev_q    <= '0;
            aligned_q <= '0;
            data_q    <= '0;
            ctrl_q    <= '0;
            de_q      <= 1'b0;
        end else begin
            prev_q    <= symbol_in;
            aligned_q <= aligned;
            if (is_tok) begin
                de_q   <= 1'b0;
                data_q <= '0;
                ctrl_q <= tok_ctrl;
            end else if (locked) begin
                de_q   <= 1'b1;
                data_q <= vid_byte;
            end else begin
                de_q   <= 1'b0;
                data_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            tok_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= '0;
        end else begin
            state_q    <= state_d;
            tok_cnt_q  <= tok_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
        end
    end

    // The run count includes the token currently in aligned_q, so lock is
    // taken in time for the first video symbol after the run to get de=1.
    always_comb begin
        if (!is_tok) begin
            tok_run = '0;
        end else if (tok_cnt_q == TOK_MAX) begin
            tok_run = TOK_MAX;
        end else begin
            tok_run = tok_cnt_q + TOK_W'(1);
        end
        tok_qual   = (tok_run == TOK_MAX);
        tmo_expire = (tmo_cnt_q == TMO_LAST);

        state_d    = state_q;
        tok_cnt_d  = tok_run;
        tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
        wait_cnt_d = wait_cnt_q;
        slip_d     = slip_q;

        case (state_q)
            ST_SEARCH: begin
                if (tok_qual) begin
                    state_d   = ST_LOCKED;
                    tmo_cnt_d = '0;
                end else if (tmo_expire) begin
                    state_d    = ST_SLIP_WAIT;
                    slip_d     = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                    tok_cnt_d  = '0;
                    tmo_cnt_d  = '0;
                    wait_cnt_d = '0;
                end
            end
            ST_SLIP_WAIT: begin
                tok_cnt_d = '0;
                tmo_cnt_d = '0;
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_SEARCH;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (tok_qual) begin
                    tmo_cnt_d = '0;
                end else if (tmo_expire) begin
                    state_d   = ST_SEARCH;
                    tok_cnt_d = '0;
                    tmo_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                tok_cnt_d  = '0;
                tmo_cnt_d  = '0;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    assign data_out    = data_q;
    assign ctrl_out    = ctrl_q;
    assign de          = de_q;
    assign slip_offset = slip_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;

    localparam int L  = 8;
    localparam int T  = 2048;
    localparam int SW = 3;
    localparam int NTX = 9600;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] symbol_in = '0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de;
    logic       locked;
    logic [3:0] slip_offset;

    always #5 clk_pixel = ~clk_pixel;

    tmds_channel_decoder #(
        .LOCK_TOKENS(L),
        .SEARCH_TIMEOUT(T),
        .SLIP_WAIT(SW)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .symbol_in(symbol_in),
        .data_out(data_out),
        .ctrl_out(ctrl_out),
        .de(de),
        .locked(locked),
        .slip_offset(slip_offset)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [9:0] s);
        symbol_in = s;
        @(posedge clk_pixel);
        @(negedge clk_pixel);
    endtask

    function automatic bit is_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    function automatic logic [1:0] token_ctrl(input logic [9:0] w);
        case (w)
            10'h0AB: return 2'b01;
            10'h154: return 2'b10;
            10'h2AB: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Transmitter-side encoding of one byte with a chosen chain mode and inversion.
    function automatic logic [9:0] tmds_enc(input logic [7:0] b, input logic inv, input logic use_xor);
        logic [7:0] qm;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xor ? (qm[i-1] ^ b[i]) : ~(qm[i-1] ^ b[i]);
        return {inv, use_xor, inv ? ~qm : qm};
    endfunction

    // Decode by finding the byte the transmitter would have sent.
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        for (int b = 0; b < 256; b++)
            if (tmds_enc(8'(b), w[9], w[8]) == w) return 8'(b);
        return 8'h00;
    endfunction

    // Reference model: timestamps instead of counters.
    int         cyc = 0;
    int         m_run = 0;
    int         m_mark = 0;
    int         m_wstart = 0;
    int         m_off = 0;
    int         m_state = 0;  // 0 search, 1 slip wait, 2 locked
    logic [9:0] m_prev = '0;
    logic [9:0] m_al = '0;
    logic [7:0] e_data = '0;
    logic [1:0] e_ctrl = '0;
    logic       e_de = 1'b0;

    always @(posedge clk_pixel) begin : model
        logic [19:0] w20;
        logic [9:0]  nxt_al;
        int          elapsed;
        if (reset) begin
            m_prev = '0; m_al = '0;
            e_data = '0; e_ctrl = '0; e_de = 1'b0;
            m_off = 0; m_state = 0; m_run = 0;
            m_mark = cyc + 1;
        end else begin
            w20    = {symbol_in, m_prev};
            nxt_al = w20[m_off +: 10];
            if (is_token(m_al)) begin
                e_de = 1'b0; e_data = '0; e_ctrl = token_ctrl(m_al);
            end else if (m_state == 2) begin
                e_de = 1'b1; e_data = ref_decode(m_al);
            end else begin
                e_de = 1'b0; e_data = '0;
            end
            if (m_state == 1) begin
                m_run = 0;
                if (cyc - m_wstart == SW - 1) begin
                    m_state = 0;
                    m_mark  = cyc + 1;
                end
            end else begin
                m_run   = is_token(m_al) ? m_run + 1 : 0;
                elapsed = cyc - m_mark;
                if (m_run >= L) begin
                    m_state = 2;
                    m_mark  = cyc + 1;
                end else if (elapsed == T - 1) begin
                    if (m_state == 0) begin
                        m_off    = (m_off + 1) % 10;
                        m_state  = 1;
                        m_wstart = cyc + 1;
                    end else begin
                        m_state = 0;
                        m_mark  = cyc + 1;
                    end
                    m_run = 0;
                end
            end
            m_al   = nxt_al;
            m_prev = symbol_in;
        end
        cyc++;
    end

    always @(negedge clk_pixel) begin
        if (chk_en)
            check("model", 32'({slip_offset, locked, de, ctrl_out, data_out}),
                  32'({4'(m_off), (m_state == 2), e_de, e_ctrl, e_data}));
    end

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] tx_byte[NTX];
    bit         tx_vid[NTX];

    initial begin
        logic [9:0] w, prev_w;
        logic [7:0] b;
        int last_off, steps, matched, left, kind;
        logic [9:0] tok_sym;

        vecs[0]  = '{10'h0AB, 1'b0, 8'h00, 2'b01};
        vecs[1]  = '{10'h100, 1'b1, 8'h00, 2'b01};
        vecs[2]  = '{10'h154, 1'b0, 8'h00, 2'b10};
        vecs[3]  = '{10'h0FF, 1'b1, 8'hFF, 2'b10};
        vecs[4]  = '{10'h2AB, 1'b0, 8'h00, 2'b11};
        vecs[5]  = '{10'h200, 1'b1, 8'hFF, 2'b11};
        vecs[6]  = '{10'h354, 1'b0, 8'h00, 2'b00};
        vecs[7]  = '{10'h155, 1'b1, 8'hFF, 2'b00};
        vecs[8]  = '{10'h101, 1'b1, 8'h03, 2'b00};
        vecs[9]  = '{10'h001, 1'b1, 8'hFD, 2'b00};
        vecs[10] = '{10'h3FF, 1'b1, 8'h00, 2'b00};

        // Reset with random symbols
        @(negedge clk_pixel);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(10'($urandom));
            chk_en = 1'b1;
            check("reset_outputs", 32'({slip_offset, locked, de, ctrl_out, data_out}), 32'h0);
        end
        reset = 1'b0;

        // Aligned token run, then video
        for (int i = 0; i < 8; i++) step(10'h354);
        step(10'h100);
        step(10'h100);
        check("lock_after_run", 32'(locked), 32'h1);
        check("lock_ctrl", 32'(ctrl_out), 32'h0);
        step(10'h100);
        check("first_video_de", 32'(de), 32'h1);
        check("first_video_data", 32'(data_out), 32'h00);

        // Decode table, each symbol held long enough to reach the output
        for (int i = 0; i < 11; i++) begin
            repeat (3) step(vecs[i].sym);
            check("vec_de", 32'(de), 32'(vecs[i].de));
            check("vec_data", 32'(data_out), 32'(vecs[i].data));
            check("vec_ctrl", 32'(ctrl_out), 32'(vecs[i].ctrl));
        end

        // Token runs while locked
        for (int t = 1; t < 4; t++) begin
            tok_sym = (t == 1) ? 10'h0AB : (t == 2) ? 10'h154 : 10'h2AB;
            repeat (8) step(tok_sym);
            check("tok_ctrl", 32'(ctrl_out), 32'(t));
            check("tok_de", 32'({de, data_out}), 32'h0);
            check("tok_locked", 32'(locked), 32'h1);
        end

        // Lock loss on continuous video, then relock without slipping
        repeat (T + 4) step(10'h100);
        check("loss_locked", 32'(locked), 32'h0);
        check("loss_offset", 32'(slip_offset), 32'h0);
        repeat (12) step(10'h354);
        check("relock_locked", 32'(locked), 32'h1);
        check("relock_offset", 32'(slip_offset), 32'h0);

        // Serial stream reframed at bit offset 4
        reset = 1'b1;
        step(10'h000);
        reset = 1'b0;
        prev_w = 10'h354;
        last_off = 0; steps = 0; matched = 0;
        for (int n = 0; n < NTX; n++) begin
            if ((n % 512) < 12) begin
                w = 10'h354;
                tx_vid[n] = 1'b0;
                tx_byte[n] = 8'h00;
            end else begin
                do begin
                    b = 8'($urandom);
                    w = tmds_enc(b, 1'($urandom), 1'($urandom));
                end while (is_token(w));
                tx_vid[n] = 1'b1;
                tx_byte[n] = b;
            end
            step({w[5:0], prev_w[9:6]});
            prev_w = w;
            if (32'(slip_offset) != last_off) begin
                check("slip_step", 32'(slip_offset), 32'((last_off + 1) % 10));
                last_off = int'(slip_offset);
                steps++;
            end
            if (de) begin
                if (n >= 2) begin
                    check("tx_byte", 32'({tx_vid[n-2], data_out}), 32'({1'b1, tx_byte[n-2]}));
                    matched++;
                end else begin
                    check("tx_early_de", 32'(de), 32'h0);
                end
            end
        end
        check("serial_offset", 32'(slip_offset), 32'h4);
        check("serial_locked", 32'(locked), 32'h1);
        check("serial_steps", 32'(steps), 32'h4);
        check("serial_bytes_seen", 32'(matched >= 100), 32'h1);

        // One-cycle reset while locked at offset 4
        reset = 1'b1;
        step(10'($urandom));
        check("pulse_offset", 32'(slip_offset), 32'h0);
        check("pulse_locked", 32'(locked), 32'h0);
        check("pulse_de", 32'(de), 32'h0);
        reset = 1'b0;

        // Random token runs and arbitrary non-token symbols against the model
        left = 0; kind = 0; tok_sym = 10'h354;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                kind = int'($urandom_range(0, 1));
                left = (kind == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 40));
                case ($urandom_range(0, 3))
                    0: tok_sym = 10'h354;
                    1: tok_sym = 10'h0AB;
                    2: tok_sym = 10'h154;
                    default: tok_sym = 10'h2AB;
                endcase
            end
            if (kind == 0) begin
                step(tok_sym);
            end else begin
                do w = 10'($urandom); while (is_token(w));
                step(w);
            end
            left--;
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
